// File: rtl/hazard_pkg.sv
// hazard_pkg: shared stage-entry type, FSM states and zero-register index
package hazard_pkg;
    localparam logic [4:0] ZERO_REG = 5'd31;
    typedef struct packed {
        logic       reg_write;
        logic       is_load;
        logic [4:0] wreg;
    } stage_entry_t;
    typedef enum logic {RUN, STALL} state_t;
endpackage

// File: rtl/stage_reg.sv
// stage_reg: one pipeline stage entry, cleared to a bubble on reset or bubble insert
module stage_reg
    import hazard_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_bubble,
    input  stage_entry_t i_d,
    output stage_entry_t o_q
);
    stage_entry_t r_q;
    always_ff @(posedge i_clk) r_q <= (!i_reset || i_bubble) ? '0 : i_d;
    assign o_q = r_q;
endmodule

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: tracks EX/MEM/WB destinations for forwarding and stalls on load-use hazards
module hazard_pipe_tracker #(
    parameter int         LOAD_USE_BUBBLES = 1,
    parameter logic [4:0] ZERO_REG         = hazard_pkg::ZERO_REG,
    parameter int         CNT_W            = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic             i_id_reg_write,
    input  logic             i_id_mem_read,
    input  logic [4:0]       i_id_rd,
    input  logic [4:0]       i_id_rn,
    input  logic [4:0]       i_id_rm,
    input  logic             i_id_uses_rn,
    input  logic             i_id_uses_rm,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_ex_reg_write,
    output logic [4:0]       o_ex_wreg,
    output logic             o_mem_reg_write,
    output logic             o_mem_is_load,
    output logic [4:0]       o_mem_wreg,
    output logic             o_wb_reg_write,
    output logic [4:0]       o_wb_wreg,
    output logic [CNT_W-1:0] o_stall_cycles
);
    import hazard_pkg::*;
    localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_BUBBLES > 1 ? LOAD_USE_BUBBLES - 2 : 0);
    stage_entry_t     w_id, w_ex, w_mem, w_wb;
    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_hazard, w_stall;
    assign w_id = '{
        reg_write: i_id_valid & i_id_reg_write & (i_id_rd != ZERO_REG),
        is_load:   i_id_valid & i_id_mem_read & (i_id_rd != ZERO_REG),
        wreg:      i_id_rd
    };
    assign w_hazard = i_id_valid & w_ex.is_load &
                      ((i_id_uses_rn & (i_id_rn == w_ex.wreg)) | (i_id_uses_rm & (i_id_rm == w_ex.wreg)));
    // flush outranks both a fresh hazard and an ongoing stall sequence
    assign w_stall = ~i_flush & ((r_state == STALL) | w_hazard);
    stage_reg u_ex  (.i_clk(i_clk), .i_reset(i_reset), .i_bubble(i_flush | w_stall), .i_d(w_id),  .o_q(w_ex));
    stage_reg u_mem (.i_clk(i_clk), .i_reset(i_reset), .i_bubble(1'b0),              .i_d(w_ex),  .o_q(w_mem));
    stage_reg u_wb  (.i_clk(i_clk), .i_reset(i_reset), .i_bubble(1'b0),              .i_d(w_mem), .o_q(w_wb));
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            if (w_stall && LOAD_USE_BUBBLES > 1) begin
                r_state <= STALL;
                r_cnt   <= CNT_INIT;
            end
        end else if (r_cnt == '0) begin
            r_state <= RUN;
        end else begin
            r_cnt <= r_cnt - 3'd1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_stall_cycles <= '0;
        else if (w_stall && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
    assign o_stall         = w_stall;
    assign o_ex_reg_write  = w_ex.reg_write;
    assign o_ex_wreg       = w_ex.wreg;
    assign o_mem_reg_write = w_mem.reg_write & ~w_mem.is_load;
    assign o_mem_is_load   = w_mem.is_load;
    assign o_mem_wreg      = w_mem.wreg;
    assign o_wb_reg_write  = w_wb.reg_write;
    assign o_wb_wreg       = w_wb.wreg;
    assign o_stall_cycles  = r_stall_cycles;
endmodule
